// File: rtl/aether_mem_pkg.sv
// Shared memory-interface definitions: command encodings and the read streamer state type.
package aether_mem_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RUN,
        ST_WAIT_FIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pop_data always shows the head entry.
module sync_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         push_data,
    output logic [Width-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(Depth));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_streamer.sv
// Splits a (start, length) read request into memory READ chunks sized to the free
// buffer space and streams the returned words out through a FIFO.
module mem_read_streamer
    import aether_mem_pkg::*;
#(
    parameter int unsigned FifoDepth = 32,
    parameter int unsigned DataBits  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_start_addr_i,
    input  logic [15:0]         req_len_i,
    output logic [1:0]          mem_command_o,
    output logic [31:0]         mem_start_address_o,
    output logic [31:0]         mem_end_address_o,
    input  logic [DataBits-1:0] mem_data_read_i,
    input  logic                mem_data_read_valid_i,
    input  logic                mem_task_finished_i,
    input  logic                mem_running_i,
    output logic [DataBits-1:0] m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int unsigned CW = $clog2(FifoDepth) + 1;

    state_t         state_q, state_d;
    logic [31:0]    addr_q;
    logic [15:0]    remaining_q, chunk_q;
    logic [CW-1:0]  outstanding_q;
    logic           fin_seen_q, err_q;

    logic [CW-1:0]  fifo_count;
    logic           fifo_empty, fifo_full;
    logic           push, pop, stray;
    logic [31:0]    free_w;
    logic [15:0]    chunk_w;
    logic           accept, issue, fin_exit;

    // Outstanding words are reserved space, so occupancy + outstanding never exceeds depth.
    assign free_w   = FifoDepth - 32'(fifo_count) - 32'(outstanding_q);
    assign chunk_w  = (32'(remaining_q) < free_w) ? remaining_q : free_w[15:0];
    assign accept   = (state_q == ST_IDLE) && req_valid_i && !rst_i;
    assign issue    = (state_q == ST_ISSUE) && !mem_running_i && (free_w != '0) && !rst_i;
    assign fin_exit = (state_q == ST_WAIT_FIN) && (mem_task_finished_i || fin_seen_q)
                      && (outstanding_q == '0);
    assign push     = mem_data_read_valid_i && (outstanding_q != '0) && !fifo_full;
    assign stray    = mem_data_read_valid_i && (outstanding_q == '0);
    assign pop      = m_valid_o && m_ready_i;

    assign m_valid_o = !fifo_empty && !rst_i;
    assign err_o     = err_q;

    sync_fifo #(
        .Width (DataBits),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .pop       (pop),
        .push_data (mem_data_read_i),
        .pop_data  (m_data_o),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        state_d             = state_q;
        req_ready_o         = 1'b0;
        mem_command_o       = CMD_IDLE;
        mem_start_address_o = '0;
        mem_end_address_o   = '0;
        done_o              = 1'b0;
        busy_o              = 1'b0;
        if (!rst_i) begin
            busy_o = (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        // A one-word range ending at address 0 would never complete.
                        if (req_len_i == '0 || (req_start_addr_i == '0 && req_len_i == 16'd1))
                            state_d = ST_DONE;
                        else
                            state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        mem_command_o       = CMD_READ;
                        mem_start_address_o = addr_q;
                        mem_end_address_o   = addr_q + 32'(chunk_w) - 32'd1;
                        state_d             = ST_WAIT_RUN;
                    end
                end
                ST_WAIT_RUN: begin
                    if (mem_running_i) state_d = ST_WAIT_FIN;
                end
                ST_WAIT_FIN: begin
                    if (fin_exit) state_d = (remaining_q == chunk_q) ? ST_DONE : ST_ISSUE;
                end
                ST_DONE: begin
                    if (fifo_empty) begin
                        done_o  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            chunk_q       <= '0;
            outstanding_q <= '0;
            fin_seen_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q      <= req_start_addr_i;
                remaining_q <= req_len_i;
                if (req_start_addr_i == '0 && req_len_i == 16'd1) err_q <= 1'b1;
            end
            if (issue) begin
                chunk_q    <= chunk_w;
                fin_seen_q <= 1'b0;
            end
            if (state_q == ST_WAIT_FIN && mem_task_finished_i) fin_seen_q <= 1'b1;
            if (fin_exit) begin
                addr_q      <= addr_q + 32'(chunk_q);
                remaining_q <= remaining_q - chunk_q;
                fin_seen_q  <= 1'b0;
            end
            outstanding_q <= outstanding_q + (issue ? CW'(chunk_w) : '0) - (push ? CW'(1) : '0);
            if (stray) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Scoreboard bench for mem_read_streamer with a behavioural memory that returns addr+0x100.
module tb_mem_read_streamer;
    import aether_mem_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 32;

    logic          clk_i = 1'b0;
    logic          rst_i, req_valid_i, req_ready_o;
    logic [31:0]   req_start_addr_i;
    logic [15:0]   req_len_i;
    logic [1:0]    mem_command_o;
    logic [31:0]   mem_start_address_o, mem_end_address_o;
    logic [DW-1:0] mem_data_read_i;
    logic          mem_data_read_valid_i, mem_task_finished_i, mem_running_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o, m_ready_i, busy_o, done_o, err_o;

    mem_read_streamer #(
        .FifoDepth (DEPTH),
        .DataBits  (DW)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_start_addr_i      (req_start_addr_i),
        .req_len_i             (req_len_i),
        .mem_command_o         (mem_command_o),
        .mem_start_address_o   (mem_start_address_o),
        .mem_end_address_o     (mem_end_address_o),
        .mem_data_read_i       (mem_data_read_i),
        .mem_data_read_valid_i (mem_data_read_valid_i),
        .mem_task_finished_i   (mem_task_finished_i),
        .mem_running_i         (mem_running_i),
        .m_data_o              (m_data_o),
        .m_valid_o             (m_valid_o),
        .m_ready_i             (m_ready_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .err_o                 (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_reads = 0, n_done = 0, n_pops = 0;
    int accept_cyc = 0, done_cyc = 0, first_read_cyc = 0;
    logic [31:0] first_start, first_end;
    bit accepted_now, prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_q[$];

    bit s_rst, s_req_valid, s_ready;
    logic [31:0] s_addr;
    logic [15:0] s_len;

    int mm_phase = 0, mm_sent = 0, mm_stall_after = -1;
    bit mm_pending = 0, mm_abort = 0, mm_stray = 0, mm_jitter = 1;
    logic [31:0] mm_addr, mm_left;

    // One clock: drive staged inputs and memory model at negedge, sample 1 unit before posedge.
    task automatic step_cycle();
        logic [31:0] tmp;
        @(negedge clk_i);
        rst_i = s_rst; req_valid_i = s_req_valid; req_start_addr_i = s_addr;
        req_len_i = s_len; m_ready_i = s_ready;
        mem_data_read_valid_i = 1'b0;
        mem_task_finished_i   = 1'b0;
        if (mm_abort) begin
            mm_phase = 0; mm_pending = 0; mm_left = '0; mm_sent = 0;
            mem_running_i = 1'b0; mm_abort = 0;
        end
        if (mm_stray) begin
            mem_data_read_valid_i = 1'b1; mem_data_read_i = 16'hDEAD; mm_stray = 0;
        end else if (mm_phase == 0) begin
            if (mm_pending) begin
                mm_pending = 0; mem_running_i = 1'b1; mm_phase = 1;
            end
        end else if (mm_left == 0) begin
            mem_task_finished_i = 1'b1; mem_running_i = 1'b0; mm_phase = 0;
        end else if (mm_sent != mm_stall_after && (!mm_jitter || $urandom_range(0, 3) != 0)) begin
            tmp = mm_addr + 32'h100;
            mem_data_read_valid_i = 1'b1; mem_data_read_i = tmp[DW-1:0];
            mm_addr = mm_addr + 1; mm_left = mm_left - 1; mm_sent++;
        end
        #4;
        cyc++;
        accepted_now = 0;
        if (!rst_i) begin
            if (mem_command_o == CMD_READ) begin
                n_reads++;
                if (n_reads == 1) begin
                    first_start = mem_start_address_o; first_end = mem_end_address_o;
                    first_read_cyc = cyc;
                end
                mm_pending = 1; mm_addr = mem_start_address_o;
                mm_left = mem_end_address_o - mem_start_address_o + 1;
            end
            if (req_valid_i && req_ready_o) begin
                accepted_now = 1; accept_cyc = cyc;
            end
            if (done_o) begin
                n_done++; done_cyc = cyc;
            end
            if (prev_stall) begin
                n_checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", m_valid_o, m_data_o, prev_data);
                end
            end
            if (m_valid_o && m_ready_i) begin
                n_checks++; n_pops++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got %h, no word expected", m_data_o);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data_o !== e) begin
                        n_fail++;
                        $display("FAIL stream_data: got %h required %h", m_data_o, e);
                    end
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
        end else begin
            prev_stall = 0;
        end
    endtask

    task automatic do_request(input logic [31:0] start, input logic [15:0] len);
        bit ok = 0;
        logic [31:0] tmp;
        s_req_valid = 1; s_addr = start; s_len = len;
        for (int i = 0; i < 40 && !ok; i++) begin
            step_cycle();
            ok = accepted_now;
        end
        s_req_valid = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready_o=%b required 1", req_ready_o);
        end
        if (len != 0 && !(start == 0 && len == 1)) begin
            for (int unsigned i = 0; i < len; i++) begin
                tmp = start + i + 32'h100;
                exp_q.push_back(tmp[DW-1:0]);
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start = n_done;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step_cycle();
            ok = (n_done != start);
        end
    endtask

    task automatic test_reset();
        s_rst = 1;
        step_cycle();
        step_cycle();
        n_checks++;
        if (req_ready_o !== 0 || mem_command_o !== CMD_IDLE || m_valid_o !== 0 || done_o !== 0 ||
            busy_o !== 0 || mem_start_address_o !== 0 || mem_end_address_o !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b cmd=%0d val=%b done=%b busy=%b sa=%h ea=%h, required all 0",
                     req_ready_o, mem_command_o, m_valid_o, done_o, busy_o, mem_start_address_o, mem_end_address_o);
        end
        s_rst = 0;
        step_cycle();
        n_checks++;
        if (req_ready_o !== 1 || err_o !== 0 || busy_o !== 0) begin
            n_fail++;
            $display("FAIL post_reset: rdy=%b err=%b busy=%b required 1 0 0", req_ready_o, err_o, busy_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int d0 = n_done;
        n_reads = 0; s_ready = 1;
        do_request(32'h10, 16'd4);
        wait_done(200, ok);
        for (int i = 0; i < 5; i++) step_cycle();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: done not seen, required 1 pulse"); end
        n_checks++;
        if (n_reads != 1 || first_start !== 32'h10 || first_end !== 32'h13) begin
            n_fail++;
            $display("FAIL basic_cmd: reads=%0d range=%h..%h required 1 0x10..0x13", n_reads, first_start, first_end);
        end
        n_checks++;
        if (first_read_cyc != accept_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_issue_latency: %0d cycles required 1", first_read_cyc - accept_cyc);
        end
        n_checks++;
        if (n_done - d0 != 1 || err_o !== 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_end: done=%0d err=%b left=%0d required 1 0 0", n_done - d0, err_o, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        n_reads = 0;
        do_request(32'h55, 16'd0);
        for (int i = 0; i < 4; i++) step_cycle();
        n_checks++;
        if (done_cyc != accept_cyc + 1 || n_reads != 0) begin
            n_fail++;
            $display("FAIL zero_len: done_delay=%0d reads=%0d required 1 0", done_cyc - accept_cyc, n_reads);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int d0 = n_done, p0 = n_pops;
        n_reads = 0; s_ready = 0;
        do_request(32'h1000, 16'd40);
        for (int i = 0; i < 90; i++) step_cycle();
        n_checks++;
        if (n_reads != 1 || first_start !== 32'h1000 || first_end !== 32'h101F || m_valid_o !== 1) begin
            n_fail++;
            $display("FAIL bp_first_chunk: reads=%0d range=%h..%h valid=%b required 1 1000..101f 1",
                     n_reads, first_start, first_end, m_valid_o);
        end
        s_ready = 1;
        wait_done(600, ok);
        for (int i = 0; i < 5; i++) step_cycle();
        n_checks++;
        if (!ok || n_done - d0 != 1 || n_pops - p0 != 40 || exp_q.size() != 0 || n_reads < 2) begin
            n_fail++;
            $display("FAIL bp_end: done=%0d pops=%0d left=%0d reads=%0d required 1 40 0 >=2",
                     n_done - d0, n_pops - p0, exp_q.size(), n_reads);
        end
    endtask

    task automatic test_random_ready();
        bit ok = 0;
        int d0 = n_done, p0 = n_pops;
        s_ready = 1;
        do_request(32'hFFFF_FFC0, 16'd100);
        for (int i = 0; i < 3000 && !ok; i++) begin
            s_ready = $urandom_range(0, 1);
            step_cycle();
            ok = (n_done != d0);
        end
        s_ready = 1;
        n_checks++;
        if (!ok || n_pops - p0 != 100 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_ready: done=%b pops=%0d left=%0d required 1 100 0", ok, n_pops - p0, exp_q.size());
        end
    endtask

    task automatic test_err_zero_addr();
        int d0 = n_done;
        n_reads = 0;
        do_request(32'h0, 16'd1);
        for (int i = 0; i < 4; i++) step_cycle();
        n_checks++;
        if (err_o !== 1 || n_done - d0 != 1 || n_reads != 0 || done_cyc != accept_cyc + 1) begin
            n_fail++;
            $display("FAIL err_zero_addr: err=%b done=%0d reads=%0d required 1 1 0", err_o, n_done - d0, n_reads);
        end
    endtask

    task automatic test_reset_mid_task();
        int r0;
        s_rst = 1; step_cycle(); s_rst = 0; step_cycle();
        n_checks++;
        if (err_o !== 0) begin n_fail++; $display("FAIL err_clear: err=%b required 0", err_o); end
        s_ready = 0; mm_sent = 0; mm_stall_after = 5;
        do_request(32'h200, 16'd8);
        for (int i = 0; i < 60 && mm_sent < 5; i++) step_cycle();
        for (int i = 0; i < 3; i++) step_cycle();
        n_checks++;
        if (busy_o !== 1 || m_valid_o !== 1 || mm_sent != 5) begin
            n_fail++;
            $display("FAIL mid_setup: busy=%b valid=%b sent=%0d required 1 1 5", busy_o, m_valid_o, mm_sent);
        end
        mm_abort = 1; mm_stall_after = -1; s_rst = 1;
        step_cycle();
        n_checks++;
        if (req_ready_o !== 0 || m_valid_o !== 0 || busy_o !== 0 || mem_command_o !== CMD_IDLE) begin
            n_fail++;
            $display("FAIL mid_in_reset: rdy=%b val=%b busy=%b cmd=%0d required 0 0 0 0",
                     req_ready_o, m_valid_o, busy_o, mem_command_o);
        end
        s_rst = 0; exp_q.delete(); r0 = n_reads;
        step_cycle();
        n_checks++;
        if (req_ready_o !== 1 || m_valid_o !== 0) begin
            n_fail++;
            $display("FAIL mid_after_reset: rdy=%b val=%b required 1 0", req_ready_o, m_valid_o);
        end
        mm_stray = 1;
        step_cycle();
        step_cycle();
        for (int i = 0; i < 4; i++) step_cycle();
        n_checks++;
        if (err_o !== 1 || m_valid_o !== 0 || n_reads != r0) begin
            n_fail++;
            $display("FAIL stray_word: err=%b val=%b reads=%0d required 1 0 %0d", err_o, m_valid_o, n_reads, r0);
        end
    endtask

    initial begin
        rst_i = 1; req_valid_i = 0; req_start_addr_i = '0; req_len_i = '0; m_ready_i = 0;
        mem_data_read_i = '0; mem_data_read_valid_i = 0; mem_task_finished_i = 0; mem_running_i = 0;
        s_rst = 1; s_req_valid = 0; s_addr = '0; s_len = '0; s_ready = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_random_ready();
        test_err_zero_addr();
        test_reset_mid_task();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
